// File: rtl/nonrestoring_divider.sv
// Sequential unsigned divider: one non-restoring add/subtract step per clock,
// with a final remainder correction and a start/done handshake.
module nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_sel;
  logic [WIDTH:0]   add_sum;

  // Single add/subtract unit shared by the iteration steps and the final fix-up;
  // add_sel=1 subtracts (inverted operand, carry-in 1).
  always_comb begin
    r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    add_a   = (state_q == FIX) ? r_q : r_shift;
    add_sel = (state_q == CALC) ? ~r_q[WIDTH] : 1'b0;
    add_b   = add_sel ? ~{1'b0, d_q} : {1'b0, d_q};
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_sel};
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        r_d   = add_sum;
        q_d   = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          quot_d = '1;
          rem_d  = q_q;  // Q still holds the untouched dividend
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q[WIDTH] ? add_sum[WIDTH-1:0] : r_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: all state, including the datapath registers, is reset so an aborted
  // operation leaves nothing behind; sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider (WIDTH=4): latency, results,
// divide-by-zero, ignored start while busy, back-to-back and async reset.
module tb_nonrestoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; also checks busy meanwhile.
  task automatic wait_done(input string tag, output int lat);
    bit busy_ok = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " busy-before-done"}, 32'(busy_ok), 32'd1);
    check({tag, " busy-in-done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic ez);
    int lat;
    start_op(a, b);
    wait_done(tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    check({tag, " done-one-cycle"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " quotient-held"}, 32'(quotient), 32'(eq));
    check({tag, " remainder-held"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    int lat;
    int ndone;
    logic [W-1:0] q_seen, r_seen;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic divide and sweep of boundary cases
    run("13/3", 4'd13, 4'd3, 5, 4'd4, 4'd1, 1'b0);
    run("15/1", 4'd15, 4'd1, 5, 4'd15, 4'd0, 1'b0);
    run("2/9", 4'd2, 4'd9, 5, 4'd0, 4'd2, 1'b0);
    run("0/5", 4'd0, 4'd5, 5, 4'd0, 4'd0, 1'b0);
    run("15/15", 4'd15, 4'd15, 5, 4'd1, 4'd0, 1'b0);
    run("9/4", 4'd9, 4'd4, 5, 4'd2, 4'd1, 1'b0);

    // Divide by zero, then a normal divide clears the flag
    run("7/0", 4'd7, 4'd0, 1, 4'd15, 4'd7, 1'b1);
    run("8/2", 4'd8, 4'd2, 5, 4'd4, 4'd0, 1'b0);

    // Start while busy is ignored; operand changes after capture have no effect
    start_op(4'd14, 4'd5);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd3;
    divisor  = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'd9;
    divisor  = 4'd1;
    ndone  = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        q_seen = quotient;
        r_seen = remainder;
      end
      @(negedge clk);
    end
    check("busy-start done count", 32'(ndone), 32'd1);
    check("busy-start quotient", 32'(q_seen), 32'd2);
    check("busy-start remainder", 32'(r_seen), 32'd4);

    // Back-to-back: new start accepted in the done cycle
    start_op(4'd6, 4'd4);
    wait_done("6/4", lat);
    check("6/4 latency", 32'(lat), 32'd5);
    check("6/4 quotient", 32'(quotient), 32'd1);
    check("6/4 remainder", 32'(remainder), 32'd2);
    start_op(4'd11, 4'd2);
    check("b2b previous quotient held", 32'(quotient), 32'd1);
    check("b2b previous remainder held", 32'(remainder), 32'd2);
    check("b2b busy", 32'(busy), 32'd1);
    wait_done("11/2", lat);
    check("11/2 latency", 32'(lat), 32'd5);
    check("11/2 quotient", 32'(quotient), 32'd5);
    check("11/2 remainder", 32'(remainder), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-operation
    start_op(4'd12, 4'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst quotient", 32'(quotient), 32'd0);
    check("async rst remainder", 32'(remainder), 32'd0);
    check("async rst dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("async rst no done", 32'(ndone), 32'd0);
    run("12/5 after rst", 4'd12, 4'd5, 5, 4'd2, 4'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
